// File: rtl/ysyx_25040111_axi_sram.sv
// AXI4 word-SRAM responder for the core's io_master bus.
// The read and write channels are served by independent FSMs.
// Each FSM accepts one outstanding transaction and supports FIXED and INCR bursts.
// The SRAM is four byte-lane arrays with a registered read port.
// A read and a write to the same word in the same cycle return the old data.
module ysyx_25040111_axi_sram #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  localparam int unsigned DEPTH       = 1 << ADDR_W;
  localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;
  localparam logic [3:0]  LAT_INIT    = 4'(RD_LAT);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // Byte address falls inside the SRAM window (unsigned offset from BASE).
  function automatic logic in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return {1'b0, off} < SPAN;
  endfunction

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] addr);
    return ADDR_W'((addr - BASE) >> 2);
  endfunction

  // Only INCR advances the address; FIXED and unsupported bursts stay put.
  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == 2'b01) ? addr + 32'd4 : addr;
  endfunction

  logic              up_reg;

  w_state_t          w_state_reg, w_state_next;
  logic [31:0]       waddr_reg;
  logic [7:0]        wlen_reg;
  logic [1:0]        wburst_reg;
  logic [7:0]        wcnt_reg;
  logic              werr_reg;
  logic              w_beat_ok, w_beat_last, w_we;
  logic [ADDR_W-1:0] w_idx;

  r_state_t          r_state_reg, r_state_next;
  logic [31:0]       raddr_reg;
  logic [7:0]        rlen_reg;
  logic [1:0]        rburst_reg;
  logic [7:0]        rcnt_reg;
  logic [3:0]        lat_reg;
  logic              rd_ok_reg;
  logic              rlast_reg;
  logic              rd_sample;
  logic [31:0]       rd_addr, r_step_addr;
  logic [7:0]        rd_cnt, rd_len;
  logic [1:0]        rd_burst;
  logic              rd_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;

  // Ready outputs stay low through reset and rise one cycle after release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) up_reg <= 1'b0;
    else        up_reg <= 1'b1;
  end

  // ---------------- write channel ----------------

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) w_state_reg <= W_IDLE;
    else        w_state_reg <= w_state_next;
  end

  assign w_beat_ok   = in_range(waddr_reg) && !wburst_reg[1];
  assign w_beat_last = (wcnt_reg == wlen_reg);
  assign w_idx       = word_idx(waddr_reg);

  // Write FSM next state and handshake outputs; burst ends on wlast or the counted last beat.
  always_comb begin
    w_state_next = w_state_reg;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    bresp        = RESP_OKAY;
    w_we         = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        awready = up_reg;
        if (awvalid && up_reg) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          w_we = w_beat_ok;
          if (wlast || w_beat_last) w_state_next = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = werr_reg ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write burst bookkeeping: latch AW, step address per beat, accumulate the error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waddr_reg  <= '0;
      wlen_reg   <= '0;
      wburst_reg <= '0;
      wcnt_reg   <= '0;
      werr_reg   <= 1'b0;
    end else if (w_state_reg == W_IDLE && awvalid && up_reg) begin
      waddr_reg  <= awaddr;
      wlen_reg   <= awlen;
      wburst_reg <= awburst;
      wcnt_reg   <= '0;
      werr_reg   <= awburst[1];
    end else if (w_state_reg == W_DATA && wvalid) begin
      waddr_reg <= step_addr(waddr_reg, wburst_reg);
      wcnt_reg  <= wcnt_reg + 8'd1;
      if (!w_beat_ok || (wlast != w_beat_last)) werr_reg <= 1'b1;
    end
  end

  // ---------------- read channel ----------------

  // Read FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state_reg <= R_IDLE;
    else        r_state_reg <= r_state_next;
  end

  assign r_step_addr = step_addr(raddr_reg, rburst_reg);

  // Read FSM next state; also picks which address/beat the SRAM samples this cycle.
  always_comb begin
    r_state_next = r_state_reg;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rd_sample    = 1'b0;
    rd_addr      = raddr_reg;
    rd_cnt       = rcnt_reg;
    rd_len       = rlen_reg;
    rd_burst     = rburst_reg;
    case (r_state_reg)
      R_IDLE: begin
        arready = up_reg;
        if (arvalid && up_reg) begin
          if (RD_LAT == 0) begin
            rd_sample    = 1'b1;
            rd_addr      = araddr;
            rd_cnt       = 8'd0;
            rd_len       = arlen;
            rd_burst     = arburst;
            r_state_next = R_DATA;
          end else begin
            r_state_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (lat_reg <= 4'd1) begin
          rd_sample    = 1'b1;
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          if (rlast_reg) begin
            r_state_next = R_IDLE;
          end else if (RD_LAT == 0) begin
            rd_sample = 1'b1;
            rd_addr   = r_step_addr;
            rd_cnt    = rcnt_reg + 8'd1;
          end else begin
            r_state_next = R_WAIT;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  assign rd_ok  = in_range(rd_addr) && !rd_burst[1];
  assign rd_idx = word_idx(rd_addr);

  // Read burst bookkeeping: latch AR, latency countdown, per-beat status capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      raddr_reg  <= '0;
      rlen_reg   <= '0;
      rburst_reg <= '0;
      rcnt_reg   <= '0;
      lat_reg    <= '0;
      rd_ok_reg  <= 1'b0;
      rlast_reg  <= 1'b0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid && up_reg) begin
            raddr_reg  <= araddr;
            rlen_reg   <= arlen;
            rburst_reg <= arburst;
            rcnt_reg   <= '0;
            lat_reg    <= LAT_INIT;
          end
        end
        R_WAIT: lat_reg <= lat_reg - 4'd1;
        R_DATA: begin
          if (rready && !rlast_reg) begin
            raddr_reg <= r_step_addr;
            rcnt_reg  <= rcnt_reg + 8'd1;
            lat_reg   <= LAT_INIT;
          end
        end
        default: ;
      endcase
      if (rd_sample) begin
        rd_ok_reg <= rd_ok;
        rlast_reg <= (rd_cnt == rd_len);
      end
    end
  end

  // ---------------- storage ----------------

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      // One byte lane: strobed write, registered read (old data on same-cycle collision).
      always_ff @(posedge clock) begin
        if (w_we && wstrb[gi]) mem[w_idx] <= wdata[8*gi +: 8];
        if (rd_sample) q_reg <= mem[rd_idx];
      end

      assign rd_word[8*gi +: 8] = q_reg;
    end
  endgenerate

  assign rdata = (rvalid && rd_ok_reg) ? rd_word : 32'h0;
  assign rresp = (rvalid && !rd_ok_reg) ? RESP_SLVERR : RESP_OKAY;
  assign rlast = rvalid && rlast_reg;

endmodule

// File: tb/tb_ysyx_25040111_axi_sram.sv
// Scoreboard bench for the AXI SRAM responder.
// Stimulus tasks push expected B/R responses computed from an associative-array memory model.
// A monitor thread pops and compares them whenever a handshake occurs.
module tb_ysyx_25040111_axi_sram;

  localparam int          RD_LAT = 3;
  localparam int          DEPTH  = 4096;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  always #5 clock = ~clock;

  ysyx_25040111_axi_sram #(.ADDR_W(12), .BASE(BASE), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      r_exp[$];
  logic [1:0]  b_exp[$];
  logic [31:0] ref_mem [int];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 0;
  bit rr_low   = 0;

  bit          mon_hold;
  logic [31:0] mon_d;
  logic [1:0]  mon_r;
  logic        mon_l;
  rbeat_t      mon_e;
  logic [1:0]  mon_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, expected handshake/response", name);
  endtask

  // ---- reference model: plain address arithmetic ----
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b, input int i);
    return (b == 2'b01) ? a + 32'(4 * i) : a;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a - BASE) < 32'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Write burst using wd/ws; wlast asserted on beat wlast_at (never if out of range).
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int wlast_at);
    bit err;
    bit hs;
    int nb;
    int t;
    logic [31:0] a;
    logic [31:0] w;
    err = burst[1];
    nb  = 0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      nb++;
      if (!addr_ok(a) || burst[1]) begin
        err = 1;
      end else begin
        w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
        for (int l = 0; l < 4; l++) if (ws[i][l]) w[8*l +: 8] = wd[i][8*l +: 8];
        ref_mem[widx(a)] = w;
      end
      if ((i == wlast_at) != (i == int'(len))) err = 1;
      if (i == wlast_at || i == int'(len)) break;
    end
    b_exp.push_back(err ? 2'b10 : 2'b00);

    @(posedge clock); #1;
    awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst;
    t = 0; hs = 0;
    while (!hs && t < 50) begin
      @(negedge clock); hs = awready;
      @(posedge clock); #1; t++;
    end
    awvalid = 1'b0;
    if (!hs) tmo("aw_handshake");
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_at);
      t = 0; hs = 0;
      while (!hs && t < 50) begin
        @(negedge clock); hs = wready;
        @(posedge clock); #1; t++;
      end
      if (!hs) begin tmo("w_handshake"); break; end
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (b_exp.size() != 0 && t < 100) begin @(posedge clock); t++; end
    if (b_exp.size() != 0) begin tmo("b_response"); b_exp.delete(); end
    @(posedge clock); #1;
  endtask

  // Issue a read burst, queue its expected beats, and check first-beat latency.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    rbeat_t e;
    logic [31:0] a;
    bit ok;
    bit hs;
    bit found;
    int t;
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, i);
      ok = addr_ok(a) && !burst[1];
      e.data = (ok && ref_mem.exists(widx(a))) ? ref_mem[widx(a)] : 32'h0;
      e.resp = ok ? 2'b00 : 2'b10;
      e.last = (i == int'(len));
      r_exp.push_back(e);
    end
    @(posedge clock); #1;
    arvalid = 1'b1; araddr = addr; arlen = len; arburst = burst;
    t = 0; hs = 0;
    while (!hs && t < 50) begin
      @(negedge clock); hs = arready;
      @(posedge clock); #1; t++;
    end
    arvalid = 1'b0;
    if (!hs) tmo("ar_handshake");
    t = 0; found = 0;
    while (!found && t < 40) begin
      @(negedge clock);
      if (rvalid) found = 1; else t++;
    end
    chk("r_first_latency", 32'(t), 32'(RD_LAT));
    @(posedge clock); #1;
  endtask

  task automatic r_drain();
    int t;
    t = 0;
    while (r_exp.size() != 0 && t < 600) begin @(posedge clock); t++; end
    if (r_exp.size() != 0) begin tmo("r_drain"); r_exp.delete(); end
    @(posedge clock); #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready), 32'd0);
    chk({tag, "_arready"}, 32'(arready), 32'd0);
    chk({tag, "_wready"},  32'(wready),  32'd0);
    chk({tag, "_bvalid"},  32'(bvalid),  32'd0);
    chk({tag, "_bresp"},   32'(bresp),   32'd0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
    chk({tag, "_rdata"},   rdata,        32'd0);
    chk({tag, "_rresp"},   32'(rresp),   32'd0);
    chk({tag, "_rlast"},   32'(rlast),   32'd0);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    @(negedge clock);
    chk("arready_first_cycle", 32'(arready), 32'd0);
    @(negedge clock);
    chk("arready_after_release", 32'(arready), 32'd1);
    chk("awready_after_release", 32'(awready), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic fill_full(input int n);
    for (int i = 0; i < 16; i++) begin
      wd[i] = (i < n) ? $urandom : 32'h0;
      ws[i] = 4'hF;
    end
  endtask

  initial begin
    reset = 1'b0;
    awvalid = 0; awaddr = 0; awlen = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    bready = 0; arvalid = 0; araddr = 0; arlen = 0; arburst = 0; rready = 0;
    fork
      begin : stim
        repeat (3) @(posedge clock);
        #1;
        chk_idle_outputs("reset");
        release_reset();

        // Known contents: words 0..63 and 4080..4095.
        for (int k = 0; k < 4; k++) begin
          fill_full(16);
          axi_write(BASE + 32'(64 * k), 8'd15, 2'b01, 15);
        end
        fill_full(16);
        axi_write(BASE + 32'(4 * 4080), 8'd15, 2'b01, 15);

        // INCR write 11,22,33,44 then read back.
        fill_full(0);
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        axi_write(32'h8000_0010, 8'd3, 2'b01, 3);
        axi_read(32'h8000_0010, 8'd3, 2'b01);
        r_drain();

        // Byte strobes over a full word.
        fill_full(0);
        wd[0] = 32'hAABB_CCDD;
        axi_write(32'h8000_0040, 8'd0, 2'b01, 0);
        wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
        axi_write(32'h8000_0040, 8'd0, 2'b01, 0);
        axi_read(32'h8000_0040, 8'd0, 2'b01);
        r_drain();

        // Out-of-range write and read.
        fill_full(1);
        axi_write(32'h8000_4000, 8'd0, 2'b01, 0);
        axi_read(32'h7FFF_FFFC, 8'd0, 2'b01);
        r_drain();

        // FIXED read with rready held low for several cycles.
        rr_low = 1;
        axi_read(32'h8000_0014, 8'd2, 2'b00);
        repeat (5) @(posedge clock);
        #1;
        rr_low = 0;
        r_drain();

        // Early wlast with a concurrent read burst elsewhere.
        fill_full(4);
        fork
          axi_write(32'h8000_0080, 8'd3, 2'b01, 1);
          begin axi_read(BASE + 32'(4 * 4084), 8'd7, 2'b01); r_drain(); end
        join
        axi_read(32'h8000_0080, 8'd3, 2'b01);
        r_drain();

        // Reset in the middle of an 8-beat read.
        axi_read(BASE, 8'd7, 2'b01);
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        r_exp.delete();
        repeat (2) @(posedge clock);
        #1;
        chk_idle_outputs("held_reset");
        release_reset();
        axi_read(32'h8000_0010, 8'd3, 2'b01);
        r_drain();

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
          logic [31:0] a;
          logic [7:0]  l;
          logic [1:0]  b;
          int          sel;
          int          wl;
          sel = $urandom_range(0, 9);
          l   = 8'($urandom_range(0, 15));
          if (sel < 6)      a = BASE + 32'(4 * $urandom_range(0, 48));
          else if (sel < 9) a = BASE + 32'(4 * $urandom_range(4088, 4095));
          else              a = 32'h7FFF_FF00 + 32'(4 * $urandom_range(0, 31));
          a[1:0] = 2'($urandom_range(0, 3));
          sel = $urandom_range(0, 9);
          b = (sel < 6) ? 2'b01 : (sel < 9) ? 2'b00 : 2'($urandom_range(2, 3));
          if ($urandom_range(0, 1) == 1) begin
            for (int i = 0; i < 16; i++) begin
              wd[i] = $urandom;
              ws[i] = 4'($urandom_range(0, 15));
            end
            sel = $urandom_range(0, 9);
            wl = (sel < 7) ? int'(l) : (sel < 9) ? int'($urandom_range(0, int'(l))) : 255;
            axi_write(a, l, b, wl);
          end else begin
            axi_read(a, l, b);
            r_drain();
          end
        end

        chk("r_queue_empty", 32'(r_exp.size()), 32'd0);
        chk("b_queue_empty", 32'(b_exp.size()), 32'd0);
        done = 1;
      end

      begin : monitor
        mon_hold = 0;
        while (!done) begin
          @(negedge clock);
          if (!reset) begin
            mon_hold = 0;
          end else begin
            if (mon_hold) begin
              chk("r_valid_held", 32'(rvalid), 32'd1);
              chk("r_data_stable", rdata, mon_d);
              chk("r_resp_stable", 32'(rresp), 32'(mon_r));
              chk("r_last_stable", 32'(rlast), 32'(mon_l));
            end
            mon_hold = rvalid && !rready;
            mon_d = rdata; mon_r = rresp; mon_l = rlast;
            if (rvalid && rready) begin
              if (r_exp.size() == 0) begin
                n_checks++;
                $display("FAIL r_extra_beat: got beat data %h, expected no beat", rdata);
              end else begin
                mon_e = r_exp.pop_front();
                chk("r_data", rdata, mon_e.data);
                chk("r_resp", 32'(rresp), 32'(mon_e.resp));
                chk("r_last", 32'(rlast), 32'(mon_e.last));
              end
            end
            if (bvalid && bready) begin
              if (b_exp.size() == 0) begin
                n_checks++;
                $display("FAIL b_extra: got bresp %h, expected no response", bresp);
              end else begin
                mon_b = b_exp.pop_front();
                chk("b_resp", 32'(bresp), 32'(mon_b));
              end
            end
          end
        end
      end

      begin : drivers
        while (!done) begin
          @(posedge clock);
          #1;
          rready = rr_low ? 1'b0 : ($urandom_range(0, 3) != 0);
          bready = ($urandom_range(0, 2) != 0);
        end
      end

      begin : watchdog
        int c;
        c = 0;
        while (!done) begin
          @(posedge clock);
          c++;
          if (c > 80000) begin
            tmo("global_watchdog");
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "watchdog expired");
          end
        end
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
